// File: rtl/vector_mem_unit_if.sv
// ============================================================================
// Module      : vector_mem_if
// Description : Command, load and store handshake bundle for vector_mem_unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface vector_mem_if #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int AW    = 10
);
    logic                  start;
    logic                  wr_wom;
    logic                  algorithm;
    logic [31:0]           i;
    logic [31:0]           j;
    logic [31:0]           n;
    logic [15:0]           count;
    logic [LANES*DW-1:0]   in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [AW-1:0]         wr_addr;
    logic                  busy;
    logic                  done;

    modport master (
        output start, wr_wom, algorithm, i, j, n, count,
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, wr_addr, busy, done
    );

    modport slave (
        input  start, wr_wom, algorithm, i, j, n, count,
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, wr_addr, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/vector_mem_unit.sv
// ============================================================================
// Module      : vector_mem_unit
// Description : DEPTH-word vector memory with row/column burst load and store.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module vector_mem_unit #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    vector_mem_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_ST   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]          r_state;
    logic [AW-1:0]       r_vec_addr;
    logic [AW-1:0]       r_stride;
    logic                r_col;
    logic [15:0]         r_remain;
    logic [LANES*DW-1:0] r_out_data;
    logic [DW-1:0]       r_mem [DEPTH];

    logic [AW-1:0]       w_base;
    logic [AW-1:0]       w_step;
    logic [AW-1:0]       w_lane_addr [LANES];
    logic                w_rd_hs;
    logic                w_st_hs;
    logic                w_last;
    logic                w_unused;

    // Only the low AW bits of the matrix coordinates matter: everything wraps modulo DEPTH.
    assign w_base   = bus.i[AW-1:0] * bus.n[AW-1:0] + bus.j[AW-1:0];
    assign w_unused = &{1'b0, bus.i[31:AW], bus.j[31:AW], bus.n[31:AW]};

    assign w_step   = r_col ? AW'(1) : AW'(LANES);
    assign w_rd_hs  = (r_state == S_HOLD) && bus.out_ready;
    assign w_st_hs  = (r_state == S_ST) && bus.in_valid;
    assign w_last   = (r_remain == 16'd1);

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_lane_addr[k] = r_vec_addr + (r_col ? AW'(k) * r_stride : AW'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_vec_addr <= '0;
            r_stride   <= '0;
            r_col      <= 1'b0;
            r_remain   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_vec_addr <= w_base;
                        r_stride   <= bus.n[AW-1:0];
                        r_col      <= bus.algorithm;
                        r_remain   <= bus.count;
                        if (bus.count == 16'd0) begin
                            r_state <= S_FIN;
                        end else if (bus.wr_wom) begin
                            r_state <= S_ST;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_rd_hs) begin
                        r_vec_addr <= r_vec_addr + w_step;
                        r_remain   <= r_remain - 16'd1;
                        r_state    <= w_last ? S_FIN : S_RD;
                    end
                end
                S_ST: begin
                    if (w_st_hs) begin
                        r_vec_addr <= r_vec_addr + w_step;
                        r_remain   <= r_remain - 16'd1;
                        r_state    <= w_last ? S_FIN : S_ST;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read register is reset, the array itself is not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (r_state == S_RD) begin
            for (int k = 0; k < LANES; k++) begin
                r_out_data[k*DW +: DW] <= r_mem[w_lane_addr[k]];
            end
        end
    end

    // Later lanes overwrite earlier ones when a zero stride makes addresses collide.
    always_ff @(posedge clk) begin
        if (w_st_hs) begin
            for (int k = 0; k < LANES; k++) begin
                r_mem[w_lane_addr[k]] <= bus.in_data[k*DW +: DW];
            end
        end
    end

    assign bus.in_ready  = (r_state == S_ST);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.out_data  = r_out_data;
    assign bus.wr_addr   = r_vec_addr;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_FIN);

endmodule

`default_nettype wire
